apb_write_master: RTL
=====================

Name: apb_write_master

Overview:
- Initiator (requester) end of the Watermark APB configuration bus; drives PADDR/PSEL/PENABLE/PWRITE/PWDATA toward the Watermark slave.
- Accepts write requests (address + data) over a valid/ready handshake, buffers them in a small FIFO and issues APB write transfers in order.
- Used as the synthesizable stimulus/bus-driver for loading image and watermark data.
- The APB subset has no PREADY and no PSLVERR: every ACCESS phase completes in exactly one cycle.

Parameters:
- Amba_Addr_Depth, 20, APB address width (legal values 20/24/32).
- Amba_Word, 16, APB data width (legal values 16/24/32).
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_addr  in  Amba_Addr_Depth  request address.
- req_data  in  Amba_Word  request write data.
- req_ready  out  1  FIFO can accept (= !full).
- PADDR  out  Amba_Addr_Depth  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write strobe.
- PWDATA  out  Amba_Word  APB write data.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- wr_count  out  CNT_W  completed APB transfers.

Behaviour:
- Reset (async, active-high): all outputs are 0, FSM is IDLE, FIFO is empty, pointers and wr_count are 0. req_ready is 0 while rst is high and 1 in the first cycle after release.
- All outputs are registered except req_ready, which is combinational from the full flag.
- Push: req_valid && req_ready at a rising edge writes {req_addr, req_data} into the FIFO.
- Full: req_ready=0. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when the FIFO is non-empty. On that edge, load PADDR/PWDATA from the FIFO head and pop it. Outputs: PSEL=1, PENABLE=0, PWRITE=1.
- SETUP -> ACCESS unconditionally. Outputs: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE held stable.
- ACCESS -> SETUP (back-to-back) if the FIFO is non-empty: load and pop the next entry, PENABLE=0, PSEL stays 1. Otherwise ACCESS -> IDLE: PSEL=0, PENABLE=0, PWRITE=0; PADDR/PWDATA keep their last values.
- wr_count increments on every edge leaving ACCESS and wraps at 2^CNT_W.
- Latency: a request accepted at edge E0 into an empty, idle block gives PSEL=1 after E1, PENABLE=1 after E2, transfer complete at E3.
- Steady-state throughput: one transfer per 2 cycles.
- A request pushed at the same edge the FSM samples an empty FIFO is issued one cycle later. No bypass path.
- PENABLE=1 never occurs without PSEL=1.
- Reset mid-transfer drops PSEL/PENABLE immediately and discards all FIFO contents.
- busy=0 only when IDLE and the FIFO is empty.

Optional Feature:
- Macro APB_IDLE_GAP_EN.
- Defined: ACCESS always goes to IDLE. At least one cycle with PSEL=0 separates consecutive transfers, giving 3 cycles per transfer.
- Undefined: back-to-back ACCESS -> SETUP as described above.
- In both cases wr_count, FIFO behaviour and transfer ordering are unchanged.

Test Plan:
- Reset release, then one request addr=0x00010, data=0x00AB: PSEL rises at cycle 2, PENABLE at cycle 3 with PADDR=0x00010, PWDATA=0x00AB, PWRITE=1; wr_count=1, busy=0 at cycle 4.
- Push 4 requests back-to-back (data 1..4): req_ready never drops below fifo space; APB carries data 1,2,3,4 in order; PSEL held continuously with PENABLE toggling 0,1,0,1...; wr_count=4. With APB_IDLE_GAP_EN, PSEL=0 for one cycle between transfers.
- Hold req_valid=1 for 8 requests: FIFO fills, req_ready=0 while fifo_level=4; no request lost or duplicated; all 8 transfers are seen in order.
- Assert rst during the ACCESS of the second of 3 queued transfers: PSEL/PENABLE=0 immediately, fifo_level=0, wr_count=0; after release, no further APB activity.
- Preload wr_count near wrap (CNT_W=4, 17 transfers): wr_count reads 1 at the end.
- Push one request exactly as the FSM returns to IDLE: transfer issued once, PENABLE never high without PSEL.

Source files
------------

// File: rtl/apb_write_master.sv
// apb_write_master: requester end of the Watermark APB configuration bus.
// Write requests (address + data) arrive over a valid/ready handshake, are
// buffered in a small FIFO and issued in order as APB write transfers.
// The APB subset has no PREADY/PSLVERR, so every ACCESS phase lasts one cycle.
// Optional macro APB_IDLE_GAP_EN: when defined, every transfer returns to IDLE
// so consecutive transfers are separated by at least one PSEL=0 cycle.
module apb_write_master #(
    parameter int Amba_Addr_Depth = 20,
    parameter int Amba_Word       = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    input  logic [Amba_Addr_Depth-1:0]      req_addr,
    input  logic [Amba_Word-1:0]            req_data,
    output logic                            req_ready,
    output logic [Amba_Addr_Depth-1:0]      PADDR,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [Amba_Word-1:0]            PWDATA,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]                wr_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                       state_q, state_d;
    logic [Amba_Addr_Depth-1:0]   addr_mem [FIFO_DEPTH];
    logic [Amba_Word-1:0]         data_mem [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]                level_q, level_d;
    logic                         full, empty, push, pop;

    logic [Amba_Addr_Depth-1:0]   paddr_q, paddr_d;
    logic [Amba_Word-1:0]         pwdata_q, pwdata_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;
    logic                         pwrite_q, pwrite_d;
    logic                         busy_q, busy_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    // Ready depends only on the registered full flag, so a pop in the same
    // cycle never frees room for a push.
    assign req_ready = ~full & ~rst;
    assign push      = req_valid & req_ready;

    // FIFO storage: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= req_addr;
            data_mem[wr_ptr_q] <= req_data;
        end
    end

    // FIFO occupancy: push and pop together leave the level unchanged
    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // APB sequencer next state and registered output values
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = SETUP;
                    pop       = 1'b1;
                    paddr_d   = addr_mem[rd_ptr_q];
                    pwdata_d  = data_mem[rd_ptr_q];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
`ifdef APB_IDLE_GAP_EN
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
`else
                if (!empty) begin
                    state_d   = SETUP;
                    pop       = 1'b1;
                    paddr_d   = addr_mem[rd_ptr_q];
                    pwdata_d  = data_mem[rd_ptr_q];
                    penable_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (level_d != '0);
    end

    // State, pointers and registered outputs with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q   <= level_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign wr_count   = cnt_q;

endmodule
